// File: rtl/sha256_core_arb.sv
// Round-robin arbiter and sequencer sharing one sha256_core among NREQ clients.
// Define SHA_ARB_TIMEOUT_EN to enable the core watchdog abort path.
module sha256_core_arb #(
    parameter int NREQ           = 2,
    parameter int IDW            = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [512*NREQ-1:0]    req_block,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [255:0]           rsp_hash,
    output logic                   rsp_err,
    input  logic                   rsp_ready,
    output logic                   core_start,
    output logic [511:0]           core_block,
    input  logic [255:0]           core_hash,
    input  logic                   core_ready
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LO,
        WAIT_HI,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] gsel;
    logic           grant;
    logic           rsp_done;
    logic           core_done;
    logic           timeout;

    // Lowest valid index above ptr wins; otherwise lowest valid index at or below it.
    always_comb begin
        gsel = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_valid[j] && (IDW'(j) <= ptr)) gsel = IDW'(j);
        end
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_valid[j] && (IDW'(j) > ptr)) gsel = IDW'(j);
        end
    end

    assign grant     = rst && (state == IDLE) && core_ready && (|req_valid);
    assign rsp_done  = (state == RESP) && rsp_ready;
    assign core_done = (state == WAIT_HI) && core_ready;

`ifdef SHA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == START) begin
            cnt <= '0;
        end else if ((state == WAIT_LO) || (state == WAIT_HI)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = ((state == WAIT_LO) || (state == WAIT_HI)) &&
                     !core_done && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (rsp_done) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end

    assign rsp_err = err;
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    req_ready[gsel] = 1'b1;
                    state_nx        = START;
                end
            end
            START: begin
                core_start = 1'b1;
                state_nx   = WAIT_LO;
            end
            WAIT_LO: begin
                if (timeout) state_nx = RESP;
                else if (!core_ready) state_nx = WAIT_HI;
            end
            WAIT_HI: begin
                if (core_done || timeout) state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            core_block <= '0;
            cur_id     <= '0;
            ptr        <= IDW'(NREQ - 1);
            rsp_id     <= '0;
            rsp_hash   <= '0;
        end else begin
            if (grant) begin
                core_block <= req_block[int'(gsel) * 512 +: 512];
                cur_id     <= gsel;
            end
            if (core_done) begin
                rsp_hash <= core_hash;
                rsp_id   <= cur_id;
            end else if (timeout) begin
                rsp_hash <= '0;
                rsp_id   <= cur_id;
            end
            if (rsp_done) begin
                ptr <= cur_id;
            end
        end
    end

endmodule

// File: tb/tb_sha256_core_arb.sv
// Directed bench for sha256_core_arb with a behavioural core model
// that returns known SHA-256 digests for the "abc" and empty blocks.
module tb_sha256_core_arb;

    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam int TOC  = 16;
    localparam int LAT  = 4;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [255:0] ABC_H =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_H =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [512*NREQ-1:0]  req_block;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [255:0]         rsp_hash;
    logic                 rsp_err;
    logic                 rsp_ready;
    logic                 core_start;
    logic [511:0]         core_block;
    logic [255:0]         core_hash;
    logic                 core_ready;

    sha256_core_arb #(
        .NREQ(NREQ),
        .IDW(IDW),
        .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_block(req_block),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_hash(rsp_hash),
        .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .core_start(core_start),
        .core_block(core_block),
        .core_hash(core_hash),
        .core_ready(core_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign req_block = {EMPTY_BLK, ABC_BLK};

    // Core model: drops ready after start, raises it LAT cycles later
    logic         ready_m   = 1'b1;
    logic         core_hold = 1'b0;
    logic         stuck     = 1'b0;
    int           busy      = 0;
    logic [255:0] hash_m    = '0;
    int           start_cnt = 0;

    function automatic logic [255:0] model_hash(input logic [511:0] b);
        if (b == ABC_BLK) return ABC_H;
        if (b == EMPTY_BLK) return EMPTY_H;
        return '1;
    endfunction

    always @(posedge clk) begin
        if (core_start) begin
            ready_m <= 1'b0;
            busy    <= stuck ? 0 : LAT;
            hash_m  <= model_hash(core_block);
        end else if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1) ready_m <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (core_start) start_cnt <= start_cnt + 1;
    end

    assign core_ready = ready_m & ~core_hold;
    assign core_hash  = hash_m;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] blk_of(input int id);
        return (id == 0) ? ABC_BLK : EMPTY_BLK;
    endfunction

    task automatic run_job(input logic [1:0] mask, input int exp_id,
                           input logic [255:0] exp_hash, input int bp,
                           output int gwait);
        int           s0;
        int           t;
        logic [1:0]   oh;
        logic [255:0] h;
        oh        = 2'b01 << exp_id;
        req_valid = mask;
        #1;
        gwait = 0;
        while (req_ready == '0 && gwait < 20) begin
            @(negedge clk);
            gwait++;
        end
        chk("grant", req_ready, oh);
        s0 = start_cnt;
        @(negedge clk);
        chk("start", core_start, 1'b1);
        chk("block", core_block, blk_of(exp_id));
        chk("ready_off", req_ready, 2'b00);
        @(negedge clk);
        chk("start_pulse", core_start, 1'b0);
        t = 0;
        while (core_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (!core_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rsp_early", rsp_valid, 1'b0);
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_id", rsp_id, exp_id[0]);
        chk("rsp_hash", rsp_hash, exp_hash);
        chk("rsp_err", rsp_err, 1'b0);
        chk("n_start", start_cnt - s0, 1);
        s0 = start_cnt;
        h  = rsp_hash;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_id", rsp_id, exp_id[0]);
            chk("bp_hash", rsp_hash, exp_hash);
            chk("bp_req_ready", req_ready, 2'b00);
            chk("bp_start", core_start, 1'b0);
        end
        if (bp > 0) chk("bp_n_start", start_cnt - s0, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_clear", rsp_valid, 1'b0);
    endtask

    typedef struct {
        logic [1:0]   mask;
        int           exp_id;
        logic [255:0] exp_hash;
    } vec_t;

    vec_t vt[10];

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_hash", rsp_hash, 256'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_core_block", core_block, 512'h0);
    endtask

    initial begin
        int gw;
        vt[0] = '{2'b11, 0, ABC_H};
        vt[1] = '{2'b11, 1, EMPTY_H};
        vt[2] = '{2'b11, 0, ABC_H};
        vt[3] = '{2'b11, 1, EMPTY_H};
        vt[4] = '{2'b11, 0, ABC_H};
        vt[5] = '{2'b11, 1, EMPTY_H};
        vt[6] = '{2'b01, 0, ABC_H};
        vt[7] = '{2'b10, 1, EMPTY_H};
        vt[8] = '{2'b10, 1, EMPTY_H};
        vt[9] = '{2'b11, 0, ABC_H};

        rst       = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_job(vt[i].mask, vt[i].exp_id, vt[i].exp_hash, 0, gw);
            chk("grant_latency", gw, 0);
        end

        run_job(2'b11, 1, EMPTY_H, 20, gw);

        // Reset while the core is busy in WAIT_HI
        req_valid = 2'b01;
        #1;
        chk("wh_grant", req_ready, 2'b01);
        @(negedge clk);
        chk("wh_start", core_start, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        core_hold = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("wh_no_grant", req_ready, 2'b00);
            chk("wh_no_rsp", rsp_valid, 1'b0);
            chk("wh_no_start", core_start, 1'b0);
        end
        core_hold = 1'b0;
        #1;
        chk("wh_grant_after", req_ready, 2'b01);
        run_job(2'b01, 0, ABC_H, 0, gw);
        chk("wh_grant_latency", gw, 0);

        // Core never returns ready
        stuck     = 1'b1;
        req_valid = 2'b01;
        #1;
        chk("to_grant", req_ready, 2'b01);
        @(negedge clk);
        chk("to_start", core_start, 1'b1);
        req_valid = 2'b00;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("to_quiet", rsp_valid, 1'b0);
        end
        @(negedge clk);
`ifdef SHA_ARB_TIMEOUT_EN
        chk("to_valid", rsp_valid, 1'b1);
        chk("to_err", rsp_err, 1'b1);
        chk("to_hash", rsp_hash, 256'h0);
        chk("to_id", rsp_id, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("to_clear", rsp_valid, 1'b0);
        chk("to_err_clear", rsp_err, 1'b0);
`else
        for (int k = 0; k < 24; k++) begin
            chk("no_to_rsp", rsp_valid, 1'b0);
            chk("no_to_err", rsp_err, 1'b0);
            @(negedge clk);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/sha256_core_arb.md
# sha256_core_arb

Round-robin arbiter and sequencer that shares a single `sha256_core` between `NREQ` requesters. Each requester presents one pre-padded 512-bit block. The arbiter:
- grants one requester at a time;
- latches its block and pulses the core's start;
- tracks the core's ready handshake;
- returns the 256-bit digest tagged with the requester index.

It sits between the hashing clients and the core instance and is the only block that drives the core's `start` and `block_in`.

## Interface
- `NREQ`, 2: number of requesters; legal range 2–4.
- `IDW`, 1: width of `rsp_id`; must equal clog2(`NREQ`).
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles. Used only when `SHA_ARB_TIMEOUT_EN` is defined.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  NREQ  bit i: requester i has a block pending; held until accepted.
- `req_block`  in  512*NREQ  requester i block at [512*i+511 : 512*i], big-endian word 0 in the MSBs.
- `req_ready`  out  NREQ  one-hot acceptance; the transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid`  out  1  digest available.
- `rsp_id`  out  IDW  index of the requester the digest belongs to.
- `rsp_hash`  out  256  digest.
- `rsp_err`  out  1  watchdog abort flag; constant 0 without `SHA_ARB_TIMEOUT_EN`.
- `rsp_ready`  in  1  consumer accepts the response.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_block`  out  512  latched block driven to the core's `block_in`.
- `core_hash`  in  256  core `hash_out`.
- `core_ready`  in  1  core `ready`.

## Operation
- **FSM states:** IDLE, START, WAIT_LO, WAIT_HI, RESP.
- **IDLE**
  - Condition to grant: `core_ready`=1 and any `req_valid`.
  - Grant selection: scan from `ptr+1` modulo `NREQ` and take the first valid requester, g.
  - Grant outputs: `req_ready[g]`=1 combinationally in the same cycle; `core_block` is loaded from requester g's block; g is stored as the current id.
  - Next state: START.
- **START:** `core_start`=1 for exactly one cycle; next state WAIT_LO.
- **WAIT_LO:** wait for `core_ready`=0, which is the core acknowledging start. Next state WAIT_HI.
- **WAIT_HI:** wait for `core_ready`=1. Then load `rsp_hash` from `core_hash`, load `rsp_id` from the current id, and go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_hash`, `rsp_id` and `rsp_err` are held stable.
  - On `rsp_valid & rsp_ready`: clear `rsp_valid`, set `ptr` to the current id, return to IDLE.
- **Round-robin pointer (`ptr`):**
  - Updates only on response completion.
  - Reset value is `NREQ`-1, so requester 0 has first priority.
- **Acceptance:** `req_ready` is all zeros in every state except IDLE. At most one bit is set.
- **Block stability:** `core_block` changes only on a grant and is held from START through RESP.
- **Requester rule:** the requester must not change `req_block` while `req_valid` is high and the request is unaccepted.

## Timing
- **Reset values (`rst`=0 at a rising edge):**
  - Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_hash`=0, `rsp_err`=0, `core_start`=0, `core_block`=0.
  - Internal: state=IDLE, `ptr`=`NREQ`-1.
- **Latencies:**
  - Grant in cycle T → `core_start` in T+1.
  - `core_ready` rising edge seen at cycle U → `rsp_valid` from U+1.
- **Throughput:** after the response handshake, the earliest next grant is one cycle later, in IDLE.
- **Core busy at request time:** if `core_ready`=0 in IDLE (for example, the core is still in reset), no grant is issued and requests wait.
- **Reset mid-operation:** the job is dropped with no response. The core is not reset by this block; the IDLE guard on `core_ready` prevents overlap with the dropped job.
- **Simultaneous events:** a new `req_valid` arriving during RESP is not granted until IDLE.

## Configuration
- **`SHA_ARB_TIMEOUT_EN` defined:**
  - A cycle counter clears on `core_start` and increments in WAIT_LO and WAIT_HI.
  - When the count reaches `TIMEOUT_CYCLES`, the FSM goes to RESP with `rsp_err`=1 and `rsp_hash`=0.
  - `rsp_err` clears on the response handshake.
- **`SHA_ARB_TIMEOUT_EN` not defined:** no counter exists, `rsp_err` is tied to 0, and the arbiter waits on the core indefinitely.

## Test plan
- **Single request, "abc":** requester 0 presents the block with word0=61626380 and last word=00000018 → exactly one `core_start` pulse; `rsp_id`=0; `rsp_hash`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- **Simultaneous requests after reset:** requester 0 presents "abc" and requester 1 presents the empty-message block (80000000, rest zeros) → responses arrive in order id 0 then id 1; the id 1 hash is e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- **Fairness:** both `req_valid` bits held high continuously for 4 jobs → grants alternate 0, 1, 0, 1.
- **Backpressure:** `rsp_ready` held low for 20 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_hash` stay stable; `req_ready`=0; no `core_start`.
- **Reset during WAIT_HI:** all outputs take their reset values on the next edge and no `rsp_valid` appears. Then, with the core model holding `core_ready` low for 5 more cycles, the pending request is granted only after `core_ready`=1.
- **`SHA_ARB_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16:** the core model never raises ready → `rsp_valid`=1, `rsp_err`=1, `rsp_hash`=0 exactly 17 cycles after `core_start`. Without the macro, no response is produced.
